// File: rtl/seg7_scan_reader.sv
// Receive side of a multiplexed active-low 7-segment display bus.
// Each accepted one-hot strobe pattern is decoded back into a BCD digit and a decimal-point bit.
module seg7_scan_reader #(
  parameter int N_DIGITS       = 4,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            Seg,
  input  logic [N_DIGITS-1:0]   An,
  output logic [4*N_DIGITS-1:0] Digits,
  output logic [N_DIGITS-1:0]   Dp,
  output logic [N_DIGITS-1:0]   DigitValid,
  output logic                  FrameDone,
  output logic                  ErrPulse
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = N_DIGITS + 8;
  localparam logic [SW-1:0] STABLE_MAX   = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  logic [7:0]          seg_s1_reg, seg_s2_reg;
  logic [N_DIGITS-1:0] an_s1_reg, an_s2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_reg <= '1;
      seg_s2_reg <= '1;
      an_s1_reg  <= '1;
      an_s2_reg  <= '1;
    end else begin
      seg_s1_reg <= Seg;
      seg_s2_reg <= seg_s1_reg;
      an_s1_reg  <= An;
      an_s2_reg  <= an_s1_reg;
    end
  end

  logic [PW-1:0] sample;
  logic [PW-1:0] prev_reg;
  logic          one_hot;
  logic          changed;

  assign sample  = {an_s2_reg, seg_s2_reg};
  assign one_hot = ($countones(~an_s2_reg) == 1);
  assign changed = (sample != prev_reg);

  state_t        state_reg, state_next;
  logic [SW-1:0] stab_reg, stab_next;
  logic          accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      stab_reg  <= '0;
      prev_reg  <= '1;
    end else begin
      state_reg <= state_next;
      stab_reg  <= stab_next;
      prev_reg  <= sample;
    end
  end

  // A change always restarts the count on the new sample, even in the accept cycle,
  // so a pattern that follows immediately is not lost.
  always_comb begin
    state_next = state_reg;
    stab_next  = stab_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        stab_next = '0;
        if (one_hot) begin
          state_next = SETTLE;
          stab_next  = SW'(1);
        end
      end
      SETTLE: begin
        if (stab_reg == STABLE_MAX) begin
          accept = 1'b1;
        end
        if (changed) begin
          state_next = one_hot ? SETTLE : IDLE;
          stab_next  = one_hot ? SW'(1) : '0;
        end else if (stab_reg == STABLE_MAX) begin
          state_next = HELD;
        end else begin
          stab_next = stab_reg + SW'(1);
        end
      end
      HELD: begin
        if (changed) begin
          state_next = one_hot ? SETTLE : IDLE;
          stab_next  = one_hot ? SW'(1) : '0;
        end
      end
      default: begin
        state_next = IDLE;
        stab_next  = '0;
      end
    endcase
  end

  // The accepted pattern is the previous sample: it is the one the count was built on.
  logic [N_DIGITS-1:0] prev_an;
  logic                dec_known;
  logic [3:0]          dec_digit;
  logic                acc_dp;
  logic [N_DIGITS-1:0] acc_mask;

  assign prev_an = prev_reg[PW-1:8];
  assign acc_dp  = ~prev_reg[7];

  always_comb begin
    dec_known = 1'b1;
    dec_digit = 4'hF;
    case (prev_reg[6:0])
      7'h40:   dec_digit = 4'd0;
      7'h79:   dec_digit = 4'd1;
      7'h24:   dec_digit = 4'd2;
      7'h30:   dec_digit = 4'd3;
      7'h19:   dec_digit = 4'd4;
      7'h12:   dec_digit = 4'd5;
      7'h02:   dec_digit = 4'd6;
      7'h78:   dec_digit = 4'd7;
      7'h00:   dec_digit = 4'd8;
      7'h10:   dec_digit = 4'd9;
      7'h7F:   dec_digit = 4'hF;
      default: dec_known = 1'b0;
    endcase
  end

  assign acc_mask = (accept && dec_known) ? ~prev_an : '0;

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_pos
      logic [3:0]    digit_reg;
      logic          dp_reg;
      logic          valid_reg;
      logic [TW-1:0] tcnt_reg;

      // Accept wins over timeout; the counter saturates so valid stays cleared.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          digit_reg <= 4'hF;
          dp_reg    <= 1'b0;
          valid_reg <= 1'b0;
          tcnt_reg  <= '0;
        end else if (acc_mask[gi]) begin
          digit_reg <= dec_digit;
          dp_reg    <= acc_dp;
          valid_reg <= 1'b1;
          tcnt_reg  <= '0;
        end else if (tcnt_reg != TIMEOUT_MAX) begin
          tcnt_reg <= tcnt_reg + TW'(1);
          if (tcnt_reg == TIMEOUT_LAST) begin
            valid_reg <= 1'b0;
          end
        end
      end

      assign Digits[4*gi +: 4] = digit_reg;
      assign Dp[gi]            = dp_reg;
      assign DigitValid[gi]    = valid_reg;
    end
  endgenerate

  logic [N_DIGITS-1:0] seen_reg;
  logic                frame_reg;
  logic                err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_reg  <= '0;
      frame_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      err_reg <= accept && !dec_known;
      if (&seen_reg) begin
        frame_reg <= 1'b1;
        seen_reg  <= acc_mask;
      end else begin
        frame_reg <= 1'b0;
        seen_reg  <= seen_reg | acc_mask;
      end
    end
  end

  assign FrameDone = frame_reg;
  assign ErrPulse  = err_reg;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Randomised plus directed bench for seg7_scan_reader: a run-length model predicts
// accept events into a queue; a negedge monitor replays them and checks every output.
module tb_seg7_scan_reader;
  localparam int N  = 4;
  localparam int ST = 16;
  localparam int TO = 300;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [7:0]     Seg;
  logic [N-1:0]   An;
  logic [4*N-1:0] Digits;
  logic [N-1:0]   Dp;
  logic [N-1:0]   DigitValid;
  logic           FrameDone;
  logic           ErrPulse;

  seg7_scan_reader #(.N_DIGITS(N), .STABLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .Seg(Seg), .An(An), .Digits(Digits), .Dp(Dp),
    .DigitValid(DigitValid), .FrameDone(FrameDone), .ErrPulse(ErrPulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           at;
    logic [N-1:0] an;
    logic [7:0]   seg;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad = 0;
  bit  end_req = 0;
  bit  mon_done = 0;

  // decode table straight from the display encoding
  logic [6:0] codes[11] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10, 7'h7F};
  logic [3:0] vals[11]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'hF};

  function automatic bit lookup(input logic [6:0] c, output logic [3:0] d);
    d = 4'hF;
    for (int k = 0; k < 11; k++) begin
      if (codes[k] == c) begin
        d = vals[k];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // model: length of the current run of identical one-hot samples
  logic [N+7:0] m_prev;
  int           m_run;
  bit           m_done;

  task automatic step(input logic [N-1:0] an, input logic [7:0] seg);
    logic [N+7:0] pat;
    An  = an;
    Seg = seg;
    pat = {an, seg};
    if (!rst_n) begin
      m_prev = '1;
      m_run  = 0;
      m_done = 0;
    end else begin
      if (pat != m_prev) begin
        m_run  = ($countones(~an) == 1) ? 1 : 0;
        m_done = 0;
      end else if (m_run > 0 && m_run < ST) begin
        m_run++;
      end
      // 2 sync stages + count register + output register after the last sample
      if (m_run == ST && !m_done) begin
        m_done = 1;
        q.push_back('{cyc + 4, an, seg});
      end
      m_prev = pat;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [N-1:0] an, input logic [7:0] seg, input int n);
    repeat (n) step(an, seg);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    q.delete();
    repeat (n) step(An, Seg);
    rst_n = 1'b1;
  endtask

  // monitor state
  logic [3:0]   e_dig[N];
  logic [N-1:0] e_dp;
  bit   [N-1:0] has;
  int           last[N];
  bit   [N-1:0] mask;
  int           frame_at;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [4*N-1:0] exp_digits;
    logic [N-1:0]   exp_valid;
    logic           exp_err;
    logic [3:0]     d;
    bit             known;
    ev_t            ev;
    if (end_req && !mon_done) begin
      chk("queue_drained", q.size(), 0);
      mon_done = 1;
    end
    if (!rst_n) begin
      for (int i = 0; i < N; i++) e_dig[i] = 4'hF;
      e_dp     = '0;
      has      = '0;
      mask     = '0;
      frame_at = -1;
      chk("rst_digits", Digits, {(4*N){1'b1}});
      chk("rst_dp", Dp, 0);
      chk("rst_valid", DigitValid, 0);
      chk("rst_frame", FrameDone, 0);
      chk("rst_err", ErrPulse, 0);
    end else begin
      exp_err = 1'b0;
      while (q.size() > 0 && q[0].at <= cyc) begin
        ev = q.pop_front();
        chk("event_time", cyc, ev.at);
        known = lookup(ev.seg[6:0], d);
        if (!known) begin
          exp_err = 1'b1;
        end else begin
          for (int i = 0; i < N; i++) begin
            if (!ev.an[i]) begin
              e_dig[i] = d;
              e_dp[i]  = ~ev.seg[7];
              has[i]   = 1'b1;
              last[i]  = cyc;
              mask[i]  = 1'b1;
            end
          end
          if (&mask) begin
            frame_at = cyc + 1;
            mask     = '0;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        exp_digits[4*i +: 4] = e_dig[i];
        exp_valid[i] = has[i] && ((cyc - last[i]) < TO);
      end
      chk("digits", Digits, exp_digits);
      chk("dp", Dp, e_dp);
      chk("valid", DigitValid, exp_valid);
      chk("frame", FrameDone, frame_at == cyc);
      chk("err", ErrPulse, exp_err);
    end
  end

  initial begin
    logic [N-1:0] an;
    logic [7:0]   seg;
    logic [31:0]  rnd;
    int           r;
    int           dur;
    rst_n  = 1'b0;
    An     = '1;
    Seg    = '1;
    m_prev = '1;
    m_run  = 0;
    m_done = 0;
    do_reset(3);

    hold(4'b1110, 8'hA4, 20);
    hold(4'b1110, 8'hC0, 32);
    hold(4'b1101, 8'hF9, 32);
    hold(4'b1011, 8'hA4, 32);
    hold(4'b0111, 8'hB0, 32);
    hold(4'b1101, 8'h10, 16);
    for (int k = 0; k < 6; k++) hold(4'b1101, (k % 2) ? 8'h19 : 8'h10, 10);
    hold(4'b1111, 8'hC0, 50);
    hold(4'b1100, 8'hC0, 50);
    hold(4'b1110, 8'hFF, 20);
    hold(4'b1011, 8'hAA, 20);
    hold(4'b1111, 8'hFF, TO + 20);
    hold(4'b1110, 8'hC0, 12);
    do_reset(3);
    hold(4'b1110, 8'hC0, 24);

    for (int t = 0; t < 120; t++) begin
      r = $urandom_range(0, 9);
      rnd = $urandom;
      if (r < 7) an = ~(4'b0001 << $urandom_range(0, N - 1));
      else if (r < 8) an = 4'b1111;
      else an = rnd[N-1:0];
      if ($urandom_range(0, 7) == 0) seg = rnd[15:8];
      else seg = {rnd[16], codes[$urandom_range(0, 10)]};
      dur = $urandom_range(1, 40);
      hold(an, seg, dur);
    end
    hold(4'b1111, 8'hFF, 10);

    end_req = 1;
    repeat (3) @(negedge clk);
    if (!mon_done) begin
      $display("FAIL monitor_end got=0 want=1");
      $fatal(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
